valid_stream_averager: RTL and testbench
========================================

Name: valid_stream_averager

Overview:
- Consumer end of the data-valid chain: sits after any fixed-latency module whose output is qualified by a dataValid level.
- Ignores samples while dataValid is low, discards a programmable number of settling samples after dataValid rises, then block-averages 2^AVG_LOG2 consecutive valid samples.
- Emits each average with a one-cycle strobe.
- Used to decimate demodulator/filter outputs before logging or feedback.

Parameters:
- DATA_WIDTH, 16, width of the signed input and output samples.
- AVG_LOG2, 4, log2 of the block length N (N = 16); legal range 0..8.
- SETTLE_SAMPLES, 2, number of valid samples discarded after every dataValid rise; 0 disables settling.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- dataValid  in  1  level qualifier from the upstream valid generator; high means dataIn is good.
- dataIn  in  DATA_WIDTH  signed sample, sampled when dataValid = 1.
- clear  in  1  synchronous abort of the current block; same effect as reset except the output registers hold their values.
- averageOut  out  DATA_WIDTH  signed block average, held until the next block completes.
- averageValid  out  1  one-cycle pulse, high in the cycle averageOut updates.
- blockAborted  out  1  one-cycle pulse when a partially filled block is discarded.
- busy  out  1  high in SETTLE or ACCUM.

Behaviour:
- Reset:
  - State = IDLE.
  - Accumulator = 0, sample counter = 0, settle counter = 0.
  - averageOut = 0, averageValid = 0, blockAborted = 0, busy = 0.
- States:
  - IDLE: busy = 0. On dataValid = 1, load the settle counter with SETTLE_SAMPLES, then:
    - if SETTLE_SAMPLES = 0, go to ACCUM and accumulate this same sample as sample 1;
    - otherwise go to SETTLE and count this sample as discarded sample 1.
  - SETTLE: each cycle with dataValid = 1 discards one sample. When the discarded total reaches SETTLE_SAMPLES, go to ACCUM; the next valid sample is accumulation sample 1.
  - ACCUM:
    - Each cycle with dataValid = 1 adds sign-extended dataIn to the accumulator.
    - On the N-th sample:
      - averageOut <= (accumulator + dataIn) >>> AVG_LOG2, an arithmetic shift that truncates toward minus infinity;
      - averageValid = 1 for exactly one cycle, registered and valid the cycle after the N-th sample is sampled;
      - accumulator and counter restart at 0 and the state stays ACCUM, so back-to-back blocks need no re-settling.
- Accumulator width is DATA_WIDTH + AVG_LOG2, signed; no overflow is possible.
- Counter width is max(1, AVG_LOG2 + 1).
- Latency: averageValid rises 1 clk after the rising edge that samples the N-th sample.
- Throughput: one output per N valid samples; continuous dataValid gives one strobe every N cycles.
- dataValid falls:
  - In SETTLE: go to IDLE; settling restarts on the next rise.
  - In ACCUM with count = 0: go to IDLE with no pulse.
  - In ACCUM with count > 0: discard the partial sum, pulse blockAborted once, go to IDLE. averageOut is unchanged.
- The dataValid fall is detected on the first rising clk edge that samples dataValid = 0; gaps of one or more cycles count.
- Simultaneous events:
  - The N-th sample completes even if dataValid falls in the following cycle.
  - clear has priority over everything except reset:
    - clear with dataValid = 1 aborts and goes to IDLE; that sample is not used.
    - clear with a partial block pulses blockAborted.
- Reset mid-operation: immediate return to reset values; no pulses are generated.
- AVG_LOG2 = 0: every post-settle valid sample is copied to averageOut with an averageValid pulse.

Test Plan:
- DATA_WIDTH=16, AVG_LOG2=2, SETTLE=1; dataValid high continuously, dataIn = 100, 4, 8, 12, 16, 20, 24, 28, 32 → first sample discarded. averageOut = 10 with pulse after the 5th input, then 26 after the 9th; pulses exactly 4 cycles apart; busy = 1 throughout.
- Negative truncation: AVG_LOG2=2, SETTLE=0, samples −1, −2, −2, −2 → sum −7, averageOut = −2 (0xFFFE), one averageValid pulse.
- Mid-block drop: AVG_LOG2=2, SETTLE=0; 2 valid samples, then dataValid = 0 for 1 cycle → blockAborted pulses once, averageValid stays 0, averageOut keeps its previous value. Resuming needs 4 fresh samples; with SETTLE=1, one extra sample is discarded first.
- Extremes: AVG_LOG2=2, four samples of 0x7FFF → 0x7FFF; four of 0x8000 → 0x8000; no wrap.
- clear coincident with the 4th valid sample → no averageValid, blockAborted = 1, state IDLE. Reset asserted mid-block → all outputs 0 the next cycle, no pulses.
- AVG_LOG2=0, SETTLE=0; samples 5, −3 with a 1-cycle gap between → averageOut 5 then −3, two pulses, no blockAborted.

Source files
------------

// File: rtl/valid_stream_averager_if.sv
// rtl/valid_stream_averager_if.sv - sample stream in, block average and status out
// master drives samples and clear; slave is the averager.
interface valid_stream_averager_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         dataValid;
  logic signed [DATA_WIDTH-1:0] dataIn;
  logic                         clear;
  logic signed [DATA_WIDTH-1:0] averageOut;
  logic                         averageValid;
  logic                         blockAborted;
  logic                         busy;

  modport master (
    output dataValid, dataIn, clear,
    input  averageOut, averageValid, blockAborted, busy
  );

  modport slave (
    input  dataValid, dataIn, clear,
    output averageOut, averageValid, blockAborted, busy
  );
endinterface

// File: rtl/valid_stream_averager.sv
// rtl/valid_stream_averager.sv - settle-then-block-average of a dataValid-qualified stream
// Emits the floor average of every 2^AVG_LOG2 valid samples; drops partial blocks on a valid gap.
module valid_stream_averager #(
  parameter int DATA_WIDTH     = 16,
  parameter int AVG_LOG2       = 4,
  parameter int SETTLE_SAMPLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  valid_stream_averager_if.slave  io_bus
);
  localparam int ACC_W       = DATA_WIDTH + AVG_LOG2;
  localparam int CNT_W       = (AVG_LOG2 + 1 > 1) ? AVG_LOG2 + 1 : 1;
  localparam int SET_W       = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);
  localparam int N_LAST      = (1 << AVG_LOG2) - 1;
  localparam int SETTLE_LOAD = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [SET_W-1:0]         r_settle;
  logic [DATA_WIDTH-1:0]    r_avg_out;
  logic                     r_avg_valid;
  logic                     r_aborted;

  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [SET_W-1:0]         w_settle_nxt;
  logic [DATA_WIDTH-1:0]    w_avg_out_nxt;
  logic                     w_avg_valid_nxt;
  logic                     w_aborted_nxt;
  logic                     w_accum;
  logic signed [ACC_W-1:0]  w_din_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shifted;

  assign w_din_ext = ACC_W'(io_bus.dataIn);
  assign w_sum     = r_acc + w_din_ext;
  assign w_shifted = w_sum >>> AVG_LOG2;

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_settle_nxt    = r_settle;
    w_avg_out_nxt   = r_avg_out;
    w_avg_valid_nxt = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_accum         = 1'b0;

    if (io_bus.clear) begin
      w_state_nxt   = S_IDLE;
      w_acc_nxt     = '0;
      w_cnt_nxt     = '0;
      w_settle_nxt  = '0;
      w_aborted_nxt = (r_state == S_ACCUM) && (r_cnt != '0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.dataValid) begin
            // The rising-edge sample is either accumulated or counted as the first discard.
            if (SETTLE_SAMPLES == 0) begin
              w_state_nxt = S_ACCUM;
              w_accum     = 1'b1;
            end else if (SETTLE_SAMPLES == 1) begin
              w_state_nxt = S_ACCUM;
            end else begin
              w_state_nxt  = S_SETTLE;
              w_settle_nxt = SET_W'(SETTLE_LOAD);
            end
          end
        end
        S_SETTLE: begin
          if (!io_bus.dataValid) begin
            w_state_nxt  = S_IDLE;
            w_settle_nxt = '0;
          end else if (r_settle <= SET_W'(1)) begin
            w_state_nxt  = S_ACCUM;
            w_settle_nxt = '0;
          end else begin
            w_settle_nxt = r_settle - SET_W'(1);
          end
        end
        S_ACCUM: begin
          if (!io_bus.dataValid) begin
            w_state_nxt   = S_IDLE;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_aborted_nxt = (r_cnt != '0);
          end else begin
            w_accum = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    if (w_accum) begin
      if (r_cnt == CNT_W'(N_LAST)) begin
        w_avg_out_nxt   = w_shifted[DATA_WIDTH-1:0];
        w_avg_valid_nxt = 1'b1;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
      end else begin
        w_acc_nxt = w_sum;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_settle    <= w_settle_nxt;
      r_avg_out   <= w_avg_out_nxt;
      r_avg_valid <= w_avg_valid_nxt;
      r_aborted   <= w_aborted_nxt;
    end
  end

  assign io_bus.averageOut   = r_avg_out;
  assign io_bus.averageValid = r_avg_valid;
  assign io_bus.blockAborted = r_aborted;
  assign io_bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_valid_stream_averager.sv
// tb/tb_valid_stream_averager.sv - directed checks of valid_stream_averager
// Three instances: A (N=4, settle 1), B (N=4, settle 0), C (N=1, settle 0).
module tb_valid_stream_averager;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  valid_stream_averager_if #(.DATA_WIDTH(16)) ifa ();
  valid_stream_averager_if #(.DATA_WIDTH(16)) ifb ();
  valid_stream_averager_if #(.DATA_WIDTH(16)) ifc ();

  valid_stream_averager #(.DATA_WIDTH(16), .AVG_LOG2(2), .SETTLE_SAMPLES(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .io_bus(ifa.slave)
  );
  valid_stream_averager #(.DATA_WIDTH(16), .AVG_LOG2(2), .SETTLE_SAMPLES(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .io_bus(ifb.slave)
  );
  valid_stream_averager #(.DATA_WIDTH(16), .AVG_LOG2(0), .SETTLE_SAMPLES(0)) dut_c (
    .i_clk(clk), .i_reset(rst), .io_bus(ifc.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.dataValid = 0; ifa.dataIn = '0; ifa.clear = 0;
    ifb.dataValid = 0; ifb.dataIn = '0; ifb.clear = 0;
    ifc.dataValid = 0; ifc.dataIn = '0; ifc.clear = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ifa.averageOut !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", ifa.averageOut); end
    checks++;
    if ({ifa.averageValid, ifa.blockAborted, ifa.busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {ifa.averageValid, ifa.blockAborted, ifa.busy});
    end
    checks++;
    if ({ifb.busy, ifc.busy, ifb.averageOut, ifc.averageOut} !== 34'h0) begin
      errors++; $display("FAIL reset_bc: got %h want 0", {ifb.busy, ifc.busy, ifb.averageOut, ifc.averageOut});
    end
  endtask

  task automatic test_settle_average();
    int vals [9] = '{100, 4, 8, 12, 16, 20, 24, 28, 32};
    int pulses = 0;
    ifa.dataValid = 1;
    for (int i = 0; i < 9; i++) begin
      ifa.dataIn = 16'(vals[i]);
      tick();
      checks++;
      if (ifa.averageValid !== (i == 4 || i == 8)) begin
        errors++; $display("FAIL settle_strobe[%0d]: got %b want %b", i, ifa.averageValid, (i == 4 || i == 8));
      end
      checks++;
      if (ifa.busy !== 1'b1) begin errors++; $display("FAIL settle_busy[%0d]: got %b want 1", i, ifa.busy); end
      if (ifa.averageValid === 1'b1) pulses++;
      if (i == 4) begin
        checks++;
        if (ifa.averageOut !== 16'sd10) begin errors++; $display("FAIL settle_avg1: got %0d want 10", $signed(ifa.averageOut)); end
      end
      if (i == 8) begin
        checks++;
        if (ifa.averageOut !== 16'sd26) begin errors++; $display("FAIL settle_avg2: got %0d want 26", $signed(ifa.averageOut)); end
      end
    end
    ifa.dataValid = 0;
    tick();
    checks++;
    if ({ifa.blockAborted, ifa.busy, ifa.averageValid} !== 3'b000 || ifa.averageOut !== 16'sd26) begin
      errors++; $display("FAIL settle_idle: got ab=%b busy=%b out=%0d want 0 0 26", ifa.blockAborted, ifa.busy, $signed(ifa.averageOut));
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL settle_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_negative_trunc();
    int vals [4] = '{-1, -2, -2, -2};
    int pulses = 0;
    ifb.dataValid = 1;
    for (int i = 0; i < 4; i++) begin
      ifb.dataIn = 16'(vals[i]);
      tick();
      if (ifb.averageValid === 1'b1) pulses++;
    end
    checks++;
    if (ifb.averageOut !== 16'hFFFE) begin errors++; $display("FAIL neg_trunc: got %h want FFFE", ifb.averageOut); end
    ifb.dataValid = 0;
    tick();
    if (ifb.averageValid === 1'b1) pulses++;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL neg_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_mid_block_drop();
    int vals [4] = '{40, 40, 40, 44};
    int avals [5] = '{1000, 8, 8, 8, 8};
    ifb.dataValid = 1;
    ifb.dataIn = 16'sd10; tick();
    ifb.dataIn = 16'sd20; tick();
    ifb.dataValid = 0;
    tick();
    checks++;
    if ({ifb.blockAborted, ifb.averageValid} !== 2'b10 || ifb.averageOut !== 16'hFFFE) begin
      errors++; $display("FAIL drop_b: got ab=%b av=%b out=%h want 1 0 FFFE", ifb.blockAborted, ifb.averageValid, ifb.averageOut);
    end
    tick();
    checks++;
    if (ifb.blockAborted !== 1'b0) begin errors++; $display("FAIL drop_b_once: got %b want 0", ifb.blockAborted); end
    ifb.dataValid = 1;
    for (int i = 0; i < 4; i++) begin
      ifb.dataIn = 16'(vals[i]);
      tick();
      checks++;
      if (ifb.averageValid !== (i == 3)) begin errors++; $display("FAIL resume_b_strobe[%0d]: got %b want %b", i, ifb.averageValid, (i == 3)); end
    end
    checks++;
    if (ifb.averageOut !== 16'sd41) begin errors++; $display("FAIL resume_b_avg: got %0d want 41", $signed(ifb.averageOut)); end

    ifa.dataValid = 1;
    ifa.dataIn = 16'sd1; tick();
    ifa.dataIn = 16'sd2; tick();
    ifa.dataValid = 0;
    tick();
    checks++;
    if ({ifa.blockAborted, ifa.averageValid} !== 2'b10 || ifa.averageOut !== 16'sd26) begin
      errors++; $display("FAIL drop_a: got ab=%b av=%b out=%0d want 1 0 26", ifa.blockAborted, ifa.averageValid, $signed(ifa.averageOut));
    end
    ifa.dataValid = 1;
    for (int i = 0; i < 5; i++) begin
      ifa.dataIn = 16'(avals[i]);
      tick();
      checks++;
      if (ifa.averageValid !== (i == 4)) begin errors++; $display("FAIL resume_a_strobe[%0d]: got %b want %b", i, ifa.averageValid, (i == 4)); end
    end
    checks++;
    if (ifa.averageOut !== 16'sd8) begin errors++; $display("FAIL resume_a_avg: got %0d want 8", $signed(ifa.averageOut)); end
    ifa.dataValid = 0;
    ifb.dataValid = 0;
    tick();
  endtask

  task automatic test_extremes();
    ifb.dataValid = 1;
    ifb.dataIn = 16'h7FFF;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ifb.averageOut !== 16'h7FFF || ifb.averageValid !== 1'b1) begin
      errors++; $display("FAIL extreme_pos: got %h av=%b want 7FFF 1", ifb.averageOut, ifb.averageValid);
    end
    ifb.dataIn = 16'h8000;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ifb.averageOut !== 16'h8000 || ifb.averageValid !== 1'b1) begin
      errors++; $display("FAIL extreme_neg: got %h av=%b want 8000 1", ifb.averageOut, ifb.averageValid);
    end
    ifb.dataValid = 0;
    tick();
  endtask

  task automatic test_clear_and_reset();
    ifb.dataValid = 1;
    ifb.dataIn = 16'sd100;
    for (int i = 0; i < 3; i++) tick();
    ifb.clear = 1;
    tick();
    checks++;
    if ({ifb.averageValid, ifb.blockAborted, ifb.busy} !== 3'b010 || ifb.averageOut !== 16'h8000) begin
      errors++; $display("FAIL clear_4th: got av=%b ab=%b busy=%b out=%h want 0 1 0 8000",
                         ifb.averageValid, ifb.blockAborted, ifb.busy, ifb.averageOut);
    end
    ifb.clear = 0;
    ifb.dataValid = 0;
    tick();

    ifa.dataValid = 1;
    ifa.dataIn = 16'sd50;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ifa.averageValid, ifa.blockAborted, ifa.busy} !== 3'b000 || ifa.averageOut !== 16'h0000) begin
      errors++; $display("FAIL reset_mid: got av=%b ab=%b busy=%b out=%h want 0 0 0 0000",
                         ifa.averageValid, ifa.blockAborted, ifa.busy, ifa.averageOut);
    end
    ifa.dataValid = 0;
    rst = 1'b0;
    tick();
    checks++;
    if ({ifa.averageValid, ifa.blockAborted} !== 2'b00) begin
      errors++; $display("FAIL reset_nopulse: got av=%b ab=%b want 0 0", ifa.averageValid, ifa.blockAborted);
    end
  endtask

  task automatic test_avg_log2_zero();
    ifc.dataValid = 1; ifc.dataIn = 16'sd5;
    tick();
    checks++;
    if (ifc.averageOut !== 16'sd5 || ifc.averageValid !== 1'b1) begin
      errors++; $display("FAIL pass_5: got %0d av=%b want 5 1", $signed(ifc.averageOut), ifc.averageValid);
    end
    ifc.dataValid = 0;
    tick();
    checks++;
    if ({ifc.averageValid, ifc.blockAborted} !== 2'b00) begin
      errors++; $display("FAIL pass_gap: got av=%b ab=%b want 0 0", ifc.averageValid, ifc.blockAborted);
    end
    ifc.dataValid = 1; ifc.dataIn = -16'sd3;
    tick();
    checks++;
    if (ifc.averageOut !== 16'hFFFD || ifc.averageValid !== 1'b1) begin
      errors++; $display("FAIL pass_m3: got %h av=%b want FFFD 1", ifc.averageOut, ifc.averageValid);
    end
    ifc.dataValid = 0;
    tick();
    checks++;
    if ({ifc.averageValid, ifc.blockAborted} !== 2'b00) begin
      errors++; $display("FAIL pass_end: got av=%b ab=%b want 0 0", ifc.averageValid, ifc.blockAborted);
    end
  endtask

  initial begin
    test_reset();
    test_settle_average();
    test_negative_trunc();
    test_mid_block_drop();
    test_extremes();
    test_clear_and_reset();
    test_avg_log2_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
